// File: rtl/delay_seq_pkg.sv
// Shared types for the delay configuration sequencer: field widths, frame word
// packing and the transmit FSM state encoding.
package delay_seq_pkg;

   localparam logic [31:0] HEADER_DEFAULT = 32'h02002000;
   localparam int unsigned AWG_ID_W       = 4;
   localparam int unsigned PORT_W         = 4;
   localparam int unsigned DELAY_W        = 24;

   typedef struct packed {
      logic [AWG_ID_W-1:0] awg_id;
      logic [PORT_W-1:0]   port;
      logic [DELAY_W-1:0]  delay;
   } cfg_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_GAP
   } state_e;

   function automatic logic [63:0] pack_word(input logic [31:0] header, input cfg_entry_t e);
      return {header, e.awg_id, e.port, e.delay};
   endfunction

   function automatic logic port_legal(input logic [PORT_W-1:0] port);
      return (port >= 4'd1) && (port <= 4'd4);
   endfunction

endpackage

// File: rtl/delay_seq_fifo.sv
// Synchronous FIFO with occupancy counter; pushes while full and pops while
// empty are ignored.
module delay_seq_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/delay_cfg_sequencer.sv
// Queues AWG delay config entries and feeds them one frame at a time to a UART
// transmitter. Define DELAY_SEQ_PORT_CHECK_EN to drop entries with port outside 1..4.
module delay_cfg_sequencer
   import delay_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [31:0] HEADER         = HEADER_DEFAULT
) (
   input  logic                I_clk_10M,
   input  logic                I_rst_n,
   input  logic                I_cfg_valid,
   output logic                O_cfg_ready,
   input  logic [AWG_ID_W-1:0] I_cfg_awg_id,
   input  logic [PORT_W-1:0]   I_cfg_port,
   input  logic [DELAY_W-1:0]  I_cfg_delay,
   input  logic                I_tx_ready,
   output logic [63:0]         O_data,
   output logic                O_data_valid,
   output logic                O_busy,
   output logic                O_err_timeout,
   output logic                O_err_port,
   output logic [15:0]         O_sent_cnt
);

   cfg_entry_t  push_entry, head_entry;
   logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic        alive_q, cfg_ready, port_ok, timed_out;
   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [63:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        err_to_q, err_to_d;
   logic [15:0] sent_q, sent_d;

   assign push_entry = '{awg_id: I_cfg_awg_id, port: I_cfg_port, delay: I_cfg_delay};
   // Ready is held low until the first clock after reset release.
   assign cfg_ready  = alive_q & ~fifo_full;
   assign fifo_push  = I_cfg_valid & cfg_ready;
   assign fifo_pop   = (state_q == ST_LOAD);
   assign timed_out  = (cnt_q >= TIMEOUT_CYCLES);

   delay_seq_fifo #(
      .WIDTH ($bits(cfg_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (I_clk_10M),
      .rst_ni  (I_rst_n),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef DELAY_SEQ_PORT_CHECK_EN
   logic err_port_q;
   assign port_ok = port_legal(head_entry.port);

   always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
      if (!I_rst_n) err_port_q <= 1'b0;
      else          err_port_q <= (state_q == ST_LOAD) && !port_ok;
   end
   assign O_err_port = err_port_q;
`else
   assign port_ok    = 1'b1;
   assign O_err_port = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      err_to_d = 1'b0;
      sent_d   = sent_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            cnt_d = '0;
            if (port_ok) begin
               data_d  = pack_word(HEADER, head_entry);
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            // While strobing, cnt_q counts strobe cycles; otherwise it is the ready timeout.
            if (valid_q) begin
               if (cnt_q == 32'd1) begin
                  state_d = ST_WAIT_LOW;
                  cnt_d   = '0;
               end else begin
                  valid_d = 1'b1;
                  cnt_d   = cnt_q + 32'd1;
               end
            end else if (I_tx_ready) begin
               valid_d = 1'b1;
               cnt_d   = '0;
            end else if (timed_out) begin
               err_to_d = 1'b1;
               state_d  = ST_GAP;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_WAIT_LOW: begin
            if (!I_tx_ready) begin
               state_d = ST_WAIT_HIGH;
               cnt_d   = '0;
            end else if (timed_out) begin
               err_to_d = 1'b1;
               state_d  = ST_GAP;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_WAIT_HIGH: begin
            if (I_tx_ready) begin
               sent_d  = sent_q + 16'd1;
               state_d = ST_GAP;
               cnt_d   = '0;
            end else if (timed_out) begin
               err_to_d = 1'b1;
               state_d  = ST_GAP;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_GAP: begin
            if ((cnt_q + 32'd1) >= GAP_CYCLES) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_to_q <= 1'b0;
         sent_q   <= '0;
         alive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_to_q <= err_to_d;
         sent_q   <= sent_d;
         alive_q  <= 1'b1;
      end
   end

   assign O_cfg_ready   = cfg_ready;
   assign O_data        = data_q;
   assign O_data_valid  = valid_q;
   assign O_busy        = (state_q != ST_IDLE) | ~fifo_empty;
   assign O_err_timeout = err_to_q;
   assign O_sent_cnt    = sent_q;

endmodule

// File: tb/tb_delay_cfg_sequencer.sv
// Directed bench for delay_cfg_sequencer with a simple UART-ready model and a
// strobe monitor.
`timescale 1ns/1ps
module tb_delay_cfg_sequencer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned GAP   = 4;
   localparam int unsigned TMO   = 1000;
`ifdef DELAY_SEQ_PORT_CHECK_EN
   localparam int unsigned PORTS_SENT = 1;
   localparam int unsigned PORT_ERRS  = 1;
`else
   localparam int unsigned PORTS_SENT = 2;
   localparam int unsigned PORT_ERRS  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [3:0]  cfg_awg = '0;
   logic [3:0]  cfg_port = '0;
   logic [23:0] cfg_delay = '0;
   logic        tx_ready = 1'b1;
   logic [63:0] data;
   logic        data_valid, busy, err_timeout, err_port;
   logic [15:0] sent_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   delay_cfg_sequencer #(
      .FIFO_DEPTH     (DEPTH),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO),
      .HEADER         (32'h02002000)
   ) dut (
      .I_clk_10M     (clk),
      .I_rst_n       (rst_n),
      .I_cfg_valid   (cfg_valid),
      .O_cfg_ready   (cfg_ready),
      .I_cfg_awg_id  (cfg_awg),
      .I_cfg_port    (cfg_port),
      .I_cfg_delay   (cfg_delay),
      .I_tx_ready    (tx_ready),
      .O_data        (data),
      .O_data_valid  (data_valid),
      .O_busy        (busy),
      .O_err_timeout (err_timeout),
      .O_err_port    (err_port),
      .O_sent_cnt    (sent_cnt)
   );

   always #50 clk = ~clk;

   // UART ready model: mode 0 forces a level; mode 1 drops ready 2 cycles after
   // a strobe starts and restores it busy_len cycles later.
   int unsigned tx_mode = 0;
   logic        tx_force = 1'b1;
   int unsigned busy_len = 1;
   int unsigned m_st = 0, m_cnt = 0;
   logic        m_prev = 1'b0;

   always @(negedge clk) begin
      if (tx_mode == 0) begin
         tx_ready = tx_force;
         m_st = 0;
      end else begin
         case (m_st)
            0: begin
               tx_ready = 1'b1;
               if (data_valid && !m_prev) begin m_st = 1; m_cnt = 0; end
            end
            1: begin
               m_cnt++;
               if (m_cnt == 2) begin tx_ready = 1'b0; m_st = 2; m_cnt = 0; end
            end
            default: begin
               m_cnt++;
               if (m_cnt >= busy_len) begin tx_ready = 1'b1; m_st = 0; end
            end
         endcase
      end
      m_prev = data_valid;
   end

   // Strobe monitor.
   logic [63:0] words[$];
   int unsigned gaps[$];
   int unsigned cyc = 0, last_high = 0, run = 0, bad_runs = 0, unstable = 0;
   int unsigned to_pulses = 0, to_wide = 0, err_cyc = 0, port_pulses = 0;
   logic        mon_prev_v = 1'b0, mon_prev_to = 1'b0, seen_v = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (data_valid) begin
         if (!mon_prev_v) begin
            words.push_back(data);
            if (seen_v) gaps.push_back(cyc - last_high - 1);
            run = 0;
         end else if (data !== words[words.size()-1]) begin
            unstable++;
         end
         run++;
         last_high = cyc;
         seen_v = 1'b1;
      end else if (mon_prev_v && run != 2) begin
         bad_runs++;
      end
      mon_prev_v = data_valid;
      if (err_timeout) begin
         to_pulses++;
         err_cyc = cyc;
         if (mon_prev_to) to_wide++;
      end
      mon_prev_to = err_timeout;
      if (err_port) port_pulses++;
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [3:0] ga, input logic [3:0] p, input logic [23:0] d,
                       input int unsigned budget, output bit ok);
      cfg_valid = 1'b1; cfg_awg = ga; cfg_port = p; cfg_delay = d;
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         if (cfg_ready) ok = 1'b1;
         @(posedge clk); #1;
         if (ok) break;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned budget, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(3);
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cfg_ready); else n_pass++;
      n_checks++; if (data !== 64'h0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
      n_checks++; if ({data_valid, busy, err_timeout, err_port} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {data_valid, busy, err_timeout, err_port}); else n_pass++;
      n_checks++; if (sent_cnt !== 16'd0) $display("FAIL reset_sent: got %0d want 0", sent_cnt); else n_pass++;
      rst_n = 1'b1;
      tick(2);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cfg_ready); else n_pass++;
   endtask

   task automatic test_frames;
      logic [63:0] exp_w [4];
      int unsigned w0;
      bit ok;
      exp_w[0] = 64'h02002000_E1_00000A;
      exp_w[1] = 64'h02002000_E2_000014;
      exp_w[2] = 64'h02002000_E3_00001E;
      exp_w[3] = 64'h02002000_E4_000028;
      tx_mode = 1; busy_len = 700;
      w0 = words.size();
      push(4'hE, 4'd1, 24'd10, 50, ok);
      push(4'hE, 4'd2, 24'd20, 50, ok);
      push(4'hE, 4'd3, 24'd30, 50, ok);
      push(4'hE, 4'd4, 24'd40, 50, ok);
      wait_idle(5000, ok);
      n_checks++; if (!ok) $display("FAIL frames_idle: busy still %b want 0", busy); else n_pass++;
      n_checks++; if (words.size() - w0 != 4) $display("FAIL frames_count: got %0d want 4", words.size() - w0); else n_pass++;
      for (int unsigned i = 0; i < 4; i++) begin
         if (w0 + i < words.size()) begin
            n_checks++; if (words[w0+i] !== exp_w[i])
               $display("FAIL frames_word%0d: got %h want %h", i, words[w0+i], exp_w[i]); else n_pass++;
         end
      end
      n_checks++; if (sent_cnt !== 16'd4) $display("FAIL frames_sent: got %0d want 4", sent_cnt); else n_pass++;
      n_checks++; if (data !== exp_w[3]) $display("FAIL frames_hold: got %h want %h", data, exp_w[3]); else n_pass++;
      n_checks++; if (bad_runs != 0 || unstable != 0)
         $display("FAIL frames_strobe: bad_runs %0d unstable %0d want 0 0", bad_runs, unstable); else n_pass++;
   endtask

   task automatic test_fifo_full;
      int unsigned w0, t0, acc;
      bit ok, held;
      tx_mode = 0; tx_force = 1'b0;
      push(4'hF, 4'd1, 24'd0, 50, ok);
      tick(5);
      w0 = words.size(); t0 = to_pulses; acc = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         push(4'(i), 4'((i % 4) + 1), 24'(256 + i), 1, ok);
         if (ok) acc++;
      end
      n_checks++; if (acc != 8) $display("FAIL fifo_accept8: got %0d want 8", acc); else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL fifo_full_ready: got %b want 0", cfg_ready); else n_pass++;
      cfg_valid = 1'b1; cfg_awg = 4'd8; cfg_port = 4'd1; cfg_delay = 24'd264;
      held = 1'b1;
      repeat (20) begin
         if (cfg_ready) held = 1'b0;
         tick(1);
      end
      n_checks++; if (!held) $display("FAIL fifo_ninth_held: got accepted want held"); else n_pass++;
      push(4'd8, 4'd1, 24'd264, 2000, ok);
      n_checks++; if (!ok) $display("FAIL fifo_ninth_accept: got not accepted want accepted"); else n_pass++;
      tx_mode = 1; busy_len = 1;
      wait_idle(2000, ok);
      n_checks++; if (words.size() - w0 != 9) $display("FAIL fifo_frames: got %0d want 9", words.size() - w0); else n_pass++;
      for (int unsigned i = 0; i < 9 && w0 + i < words.size(); i++) begin
         logic [63:0] ew;
         ew = {32'h02002000, 4'(i), 4'((i % 4) + 1), 24'(256 + i)};
         n_checks++; if (words[w0+i] !== ew) $display("FAIL fifo_order%0d: got %h want %h", i, words[w0+i], ew); else n_pass++;
      end
      n_checks++; if (to_pulses - t0 != 1) $display("FAIL fifo_send_timeout: got %0d want 1", to_pulses - t0); else n_pass++;
      n_checks++; if (sent_cnt !== 16'd13) $display("FAIL fifo_sent: got %0d want 13", sent_cnt); else n_pass++;
   endtask

   task automatic test_timeout;
      int unsigned w0, t0;
      bit ok, seen;
      tx_mode = 0; tx_force = 1'b1;
      w0 = words.size(); t0 = to_pulses;
      push(4'd7, 4'd3, 24'h000777, 50, ok);
      push(4'd8, 4'd4, 24'h000888, 50, ok);
      seen = 1'b0;
      for (int unsigned i = 0; i < TMO + 200; i++) begin
         tick(1);
         if (to_pulses != t0) begin seen = 1'b1; break; end
      end
      tx_mode = 1; busy_len = 1;
      n_checks++; if (!seen) $display("FAIL timeout_pulse: got none want 1"); else n_pass++;
      n_checks++; if (err_cyc - last_high != TMO + 2)
         $display("FAIL timeout_latency: got %0d want %0d", err_cyc - last_high, TMO + 2); else n_pass++;
      wait_idle(500, ok);
      n_checks++; if (words.size() - w0 != 2) $display("FAIL timeout_frames: got %0d want 2", words.size() - w0); else n_pass++;
      n_checks++; if (words[words.size()-1] !== 64'h02002000_84_000888)
         $display("FAIL timeout_next: got %h want %h", words[words.size()-1], 64'h02002000_84_000888); else n_pass++;
      n_checks++; if (sent_cnt !== 16'd14) $display("FAIL timeout_sent: got %0d want 14", sent_cnt); else n_pass++;
      n_checks++; if (to_wide != 0 || to_pulses - t0 != 1)
         $display("FAIL timeout_width: wide %0d pulses %0d want 0 1", to_wide, to_pulses - t0); else n_pass++;
   endtask

   task automatic test_port;
      int unsigned w0, p0;
      bit ok;
      tx_mode = 1; busy_len = 1;
      w0 = words.size(); p0 = port_pulses;
      push(4'd3, 4'd0, 24'h123456, 50, ok);
      push(4'd5, 4'd2, 24'hABCDEF, 50, ok);
      wait_idle(500, ok);
      n_checks++; if (words.size() - w0 != PORTS_SENT)
         $display("FAIL port_frames: got %0d want %0d", words.size() - w0, PORTS_SENT); else n_pass++;
      n_checks++; if (port_pulses - p0 != PORT_ERRS)
         $display("FAIL port_err: got %0d want %0d", port_pulses - p0, PORT_ERRS); else n_pass++;
      n_checks++; if (words[words.size()-1] !== 64'h02002000_52_ABCDEF)
         $display("FAIL port_last: got %h want %h", words[words.size()-1], 64'h02002000_52_ABCDEF); else n_pass++;
      if (PORTS_SENT == 2) begin
         n_checks++; if (words[w0] !== 64'h02002000_30_123456)
            $display("FAIL port_zero_word: got %h want %h", words[w0], 64'h02002000_30_123456); else n_pass++;
      end
      n_checks++; if (sent_cnt !== 16'(14 + PORTS_SENT))
         $display("FAIL port_sent: got %0d want %0d", sent_cnt, 14 + PORTS_SENT); else n_pass++;
   endtask

   task automatic test_spacing;
      int unsigned g0, bad;
      bit ok;
      tx_mode = 1; busy_len = 1;
      g0 = gaps.size(); bad = 0;
      push(4'd1, 4'd1, 24'd1, 50, ok);
      push(4'd2, 4'd2, 24'd2, 50, ok);
      push(4'd3, 4'd3, 24'd3, 50, ok);
      wait_idle(500, ok);
      n_checks++; if (gaps.size() - g0 != 3) $display("FAIL spacing_count: got %0d want 3", gaps.size() - g0); else n_pass++;
      for (int unsigned i = g0; i < gaps.size(); i++) if (gaps[i] < GAP + 3) bad++;
      n_checks++; if (bad != 0) $display("FAIL spacing_min: got %0d short gaps (last %0d) want 0 (min %0d)",
         bad, gaps[gaps.size()-1], GAP + 3); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int unsigned w0, t0;
      bit ok, seen;
      tx_mode = 1; busy_len = 700;
      w0 = words.size();
      push(4'd9, 4'd4, 24'h00BEEF, 50, ok);
      seen = 1'b0;
      for (int unsigned i = 0; i < 100; i++) begin
         tick(1);
         if (words.size() != w0) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen) $display("FAIL rstmid_strobe: got none want 1"); else n_pass++;
      tick(10);
      rst_n = 1'b0;
      #1;
      n_checks++; if (data !== 64'h0 || data_valid !== 1'b0)
         $display("FAIL rstmid_data: got %h/%b want 0/0", data, data_valid); else n_pass++;
      n_checks++; if ({cfg_ready, busy, err_timeout, err_port} !== 4'b0000)
         $display("FAIL rstmid_flags: got %b want 0000", {cfg_ready, busy, err_timeout, err_port}); else n_pass++;
      n_checks++; if (sent_cnt !== 16'd0) $display("FAIL rstmid_sent: got %0d want 0", sent_cnt); else n_pass++;
      tx_mode = 0; tx_force = 1'b1;
      tick(2);
      rst_n = 1'b1;
      w0 = words.size(); t0 = to_pulses;
      tick(50);
      n_checks++; if (words.size() != w0 || to_pulses != t0)
         $display("FAIL rstmid_quiet: got %0d strobes %0d timeouts want 0 0", words.size() - w0, to_pulses - t0); else n_pass++;
      tx_mode = 1; busy_len = 1;
      push(4'd6, 4'd1, 24'h000042, 50, ok);
      wait_idle(500, ok);
      n_checks++; if (words.size() - w0 != 1 || words[words.size()-1] !== 64'h02002000_61_000042)
         $display("FAIL rstmid_new: got %0d frames last %h want 1 %h", words.size() - w0,
                  words[words.size()-1], 64'h02002000_61_000042); else n_pass++;
      n_checks++; if (sent_cnt !== 16'd1) $display("FAIL rstmid_new_sent: got %0d want 1", sent_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frames();
      test_fifo_full();
      test_timeout();
      test_port();
      test_spacing();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
